// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED pattern sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/led_step_timer.sv
// led_step_timer: counts 0..P-1 (P = max(period,1)) and pulses step on the last count.
module led_step_timer #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    output logic             step
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] top;
    assign top  = (period == '0) ? '0 : period - 1'b1;
    assign step = enable && (cnt == top);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= step ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps the pattern ROM address through a window in loop,
// one-shot or ping-pong order and registers the returned word onto the LEDs.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 5,
    parameter int DIV_W  = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  period,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
    state_t            state, state_nx;
    logic [1:0]        cfg_mode;
    logic [DIV_W-1:0]  cfg_period;
    logic [ADDR_W-1:0] cfg_first, cfg_last, addr_nx;
    logic              up, up_nx, done_nx, accept, step, chg, chg_d;
    assign accept = start && !stop && (first_addr <= last_addr) && ({1'b0, last_addr} < DEPTH_V);
    assign busy   = (state == ST_RUN);
    led_step_timer #(.DIV_W(DIV_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (busy),
        .period (cfg_period),
        .step   (step)
    );
    always_comb begin
        state_nx = state;
        addr_nx  = rom_addr;
        up_nx    = up;
        done_nx  = 1'b0;
        if (stop) begin
            state_nx = ST_IDLE;
        end else if (accept) begin
            state_nx = ST_RUN;
            addr_nx  = first_addr;
            up_nx    = 1'b1;
        end else if (busy && step) begin
            if (cfg_mode == MODE_ONESHOT) begin
                state_nx = (rom_addr == cfg_last) ? ST_IDLE : ST_RUN;
                done_nx  = (rom_addr == cfg_last);
                addr_nx  = (rom_addr == cfg_last) ? rom_addr : rom_addr + 1'b1;
            end else if (cfg_mode == MODE_PINGPONG) begin
                // direction flips at either end; the new direction picks the neighbour
                if (cfg_first != cfg_last) begin
                    up_nx   = up ? (rom_addr != cfg_last) : (rom_addr == cfg_first);
                    addr_nx = up_nx ? rom_addr + 1'b1 : rom_addr - 1'b1;
                end
            end else begin
                addr_nx = (rom_addr == cfg_last) ? cfg_first : rom_addr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            up         <= 1'b1;
            done       <= 1'b0;
            chg        <= 1'b0;
            chg_d      <= 1'b0;
            led        <= '0;
            cfg_mode   <= '0;
            cfg_period <= '0;
            cfg_first  <= '0;
            cfg_last   <= '0;
        end else begin
            state    <= state_nx;
            rom_addr <= addr_nx;
            up       <= up_nx;
            done     <= done_nx;
            chg      <= accept || (addr_nx != rom_addr);
            chg_d    <= chg;
            if (chg_d) led <= rom_data;
            if (accept) begin
                cfg_mode   <= mode;
                cfg_period <= period;
                cfg_first  <= first_addr;
                cfg_last   <= last_addr;
            end
        end
    end
endmodule
